// File: rtl/tft_capture_if.sv
// Video input and capture output bundle for tft_capture.
// master = timing source / consumer side, slave = capture block.
interface tft_capture_if;
  logic        vid_hs;
  logic        vid_vs;
  logic        vid_de;
  logic [15:0] vid_rgb;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        frame_start;
  logic        frame_done;
  logic [9:0]  line_len;
  logic [9:0]  frame_lines;
  logic        err;
  logic        locked;

  modport master (
    output vid_hs, vid_vs, vid_de, vid_rgb,
    input  pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done,
           line_len, frame_lines, err, locked
  );

  modport slave (
    input  vid_hs, vid_vs, vid_de, vid_rgb,
    output pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done,
           line_len, frame_lines, err, locked
  );
endinterface

// File: rtl/tft_capture.sv
// TFT parallel RGB565 capture: pixel tagging with (x,y), line/frame size
// measurement, size checking and lock detection.
module tft_capture #(
  parameter int H_ACT    = 480,
  parameter int V_ACT    = 272,
  parameter int SYNC_POL = 0
) (
  input  logic         clk,
  input  logic         rst,
  tft_capture_if.slave vid
);
  localparam logic [9:0] H_ACT_W  = 10'(H_ACT);
  localparam logic [9:0] V_ACT_W  = 10'(V_ACT);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);

  typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  // Stage p0: inputs registered, syncs normalised so that 1 = asserted
  logic        hs_p0, vs_p0, de_p0;
  logic [15:0] rgb_p0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_p0 <= 1'b0;
      vs_p0 <= 1'b0;
      de_p0 <= 1'b0;
    end else begin
      hs_p0 <= (vid.vid_hs == SYNC_ACT);
      vs_p0 <= (vid.vid_vs == SYNC_ACT);
      de_p0 <= vid.vid_de;
    end
  end

  always_ff @(posedge clk) rgb_p0 <= vid.vid_rgb;

  // Stage p1: delayed copy used only for edge detection
  logic hs_p1, vs_p1, de_p1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_p1 <= 1'b0;
      vs_p1 <= 1'b0;
      de_p1 <= 1'b0;
    end else begin
      hs_p1 <= hs_p0;
      vs_p1 <= vs_p0;
      de_p1 <= de_p0;
    end
  end

  logic hs_rise, hs_fall, vs_rise, de_rise, de_fall;
  assign hs_rise = hs_p0 & ~hs_p1;
  assign hs_fall = ~hs_p0 & hs_p1;
  assign vs_rise = vs_p0 & ~vs_p1;
  assign de_rise = de_p0 & ~de_p1;
  assign de_fall = ~de_p0 & de_p1;

  state_t      state_q, state_nxt;
  logic [9:0]  x_q, x_nxt, y_q, y_nxt;
  logic        bad_q, bad_nxt;
  logic [1:0]  good_q, good_nxt;
  logic        pv_q, pv_nxt, fs_q, fs_nxt, fd_q, fd_nxt, err_q, err_nxt, lock_q, lock_nxt;
  logic [15:0] pd_q, pd_nxt;
  logic [9:0]  px_q, px_nxt, py_q, py_nxt, ll_q, ll_nxt, fl_q, fl_nxt;
  logic        line_close, line_fail, frame_fail, line_start;
  logic [9:0]  y_cl;

  // A line may also start on hsync release so a stuck-high vid_de still works
  assign line_start = (state_q == FRAME) && de_p0 && !hs_p0 && (de_rise || hs_fall);

  always_comb begin
    state_nxt  = state_q;
    x_nxt      = x_q;
    y_nxt      = y_q;
    bad_nxt    = bad_q;
    good_nxt   = good_q;
    lock_nxt   = lock_q;
    pv_nxt     = 1'b0;
    pd_nxt     = pd_q;
    px_nxt     = px_q;
    py_nxt     = py_q;
    fs_nxt     = 1'b0;
    fd_nxt     = 1'b0;
    ll_nxt     = ll_q;
    fl_nxt     = fl_q;
    err_nxt    = 1'b0;
    frame_fail = 1'b0;
    line_close = (state_q == LINE) && (de_fall || hs_rise || vs_rise);
    line_fail  = line_close && (x_q != H_ACT_W);
    y_cl       = line_close ? sat_inc(y_q) : y_q;

    if (line_close) begin
      ll_nxt    = x_q;
      y_nxt     = y_cl;
      bad_nxt   = bad_q | line_fail;
      err_nxt   = line_fail;
      state_nxt = FRAME;
    end

    if (state_q == IDLE) begin
      if (vs_rise) begin
        state_nxt = FRAME;
        fs_nxt    = 1'b1;
        y_nxt     = 10'd0;
        bad_nxt   = 1'b0;
      end
    end else if (vs_rise) begin
      // Frame close; a line still open was closed just above in the same cycle
      fs_nxt    = 1'b1;
      state_nxt = FRAME;
      y_nxt     = 10'd0;
      bad_nxt   = 1'b0;
      if (y_cl != 10'd0) begin
        fd_nxt     = 1'b1;
        fl_nxt     = y_cl;
        frame_fail = (y_cl != V_ACT_W);
        err_nxt    = line_fail | frame_fail;
        if (bad_q | line_fail | frame_fail) begin
          good_nxt = 2'd0;
          lock_nxt = 1'b0;
        end else begin
          good_nxt = (good_q == 2'd2) ? 2'd2 : good_q + 2'd1;
          lock_nxt = (good_q != 2'd0);
        end
      end
    end else if (line_start) begin
      state_nxt = LINE;
      pv_nxt    = 1'b1;
      pd_nxt    = rgb_p0;
      px_nxt    = 10'd0;
      py_nxt    = y_q;
      x_nxt     = 10'd1;
    end else if ((state_q == LINE) && !line_close && de_p0) begin
      pv_nxt = 1'b1;
      pd_nxt = rgb_p0;
      px_nxt = x_q;
      py_nxt = y_q;
      x_nxt  = sat_inc(x_q);
    end
  end

  // Stage p2: control state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      bad_q   <= 1'b0;
      good_q  <= 2'd0;
      lock_q  <= 1'b0;
      pv_q    <= 1'b0;
      pd_q    <= 16'd0;
      px_q    <= 10'd0;
      py_q    <= 10'd0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      ll_q    <= 10'd0;
      fl_q    <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      bad_q   <= bad_nxt;
      good_q  <= good_nxt;
      lock_q  <= lock_nxt;
      pv_q    <= pv_nxt;
      pd_q    <= pd_nxt;
      px_q    <= px_nxt;
      py_q    <= py_nxt;
      fs_q    <= fs_nxt;
      fd_q    <= fd_nxt;
      ll_q    <= ll_nxt;
      fl_q    <= fl_nxt;
      err_q   <= err_nxt;
    end
  end

  assign vid.pix_valid   = pv_q;
  assign vid.pix_data    = pd_q;
  assign vid.pix_x       = px_q;
  assign vid.pix_y       = py_q;
  assign vid.frame_start = fs_q;
  assign vid.frame_done  = fd_q;
  assign vid.line_len    = ll_q;
  assign vid.frame_lines = fl_q;
  assign vid.err         = err_q;
  assign vid.locked      = lock_q;
endmodule
